packet_receiver_mp: RTL and testbench

- Parametrised successor of the 3-port custom-router packet receiver.
- Accepts byte-serial packets (SRC, DST, SIZE, DATA×n, CRC) on one input stream.
- Screens the source against a trusted-ID list, selects one of NUM_PORTS output buffers from the DST upper bits, and writes the frame into that port's buffer.
- Issues a commit pulse only for complete, trusted, checksum-clean frames; everything else is dropped and counted.

---
 rtl/packet_receiver_mp_if.sv | 30 +++
 rtl/packet_receiver_mp.sv | 214 +++++++++++++++++++++
 tb/tb_packet_receiver_mp.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/packet_receiver_mp_if.sv
// Byte-stream input and shared buffer-write bus of the multi-port packet receiver.
// master drives packets and buffer status; slave is the receiver.
interface packet_receiver_mp_if #(
    parameter int UWIDTH    = 8,
    parameter int PSEL_W    = 2,
    parameter int PTR_IN_SZ = 4,
    parameter int CNT_W     = 8
);
    localparam int NUM_PORTS = 2**PSEL_W;

    logic                 packet_valid_i;
    logic [UWIDTH-1:0]    pdata;
    logic [NUM_PORTS-1:0] wfull;
    logic                 stop_packet_send;
    logic [NUM_PORTS-1:0] wen;
    logic [PTR_IN_SZ-1:0] waddr;
    logic [UWIDTH-1:0]    wdata;
    logic [NUM_PORTS-1:0] winc;
    logic [CNT_W-1:0]     drop_cnt;

    modport master (
        output packet_valid_i, pdata, wfull,
        input  stop_packet_send, wen, waddr, wdata, winc, drop_cnt
    );

    modport slave (
        input  packet_valid_i, pdata, wfull,
        output stop_packet_send, wen, waddr, wdata, winc, drop_cnt
    );
endinterface

// File: rtl/packet_receiver_mp.sv
// Multi-port packet receiver: screens SRC, steers the frame by DST upper bits into one of
// NUM_PORTS buffers and commits clean frames. Define PKT_RX_CRC_CHECK_EN to check the CRC byte.
module packet_receiver_mp #(
    parameter int                         UWIDTH    = 8,
    parameter int                         PSEL_W    = 2,
    parameter int                         PTR_IN_SZ = 4,
    parameter int                         SZ_W      = 3,
    parameter int                         NUM_TS    = 3,
    parameter logic [NUM_TS*UWIDTH-1:0]   TS_LIST   = 24'h020100,
    parameter int                         CNT_W     = 8
) (
    input logic                 clk1,
    input logic                 rst,
    packet_receiver_mp_if.slave bus
);
    localparam int NUM_PORTS = 2**PSEL_W;

    // Largest frame occupies addresses 0 .. 2**SZ_W+1; the address counter must never wrap.
    if ((2**SZ_W) + 2 > (2**PTR_IN_SZ)) begin : g_addr_chk
        $error("packet_receiver_mp: PTR_IN_SZ too small for SZ_W");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_DST,
        S_SIZE,
        S_DATA,
        S_CRC,
        S_SKIP
    } state_t;

    state_t               state_q, state_d;
    logic                 trusted_q, trusted_d;
    logic                 keep_q, keep_d;
    logic [PSEL_W-1:0]    port_q, port_d;
    logic [SZ_W-1:0]      len_q, len_d;
    logic [PTR_IN_SZ-1:0] addr_q, addr_d;
    logic                 stop_q, stop_d;
    logic [NUM_PORTS-1:0] wen_q, wen_d;
    logic [PTR_IN_SZ-1:0] waddr_q, waddr_d;
    logic [UWIDTH-1:0]    wdata_q, wdata_d;
    logic [1:0]           cmt_pipe_q, cmt_pipe_d;
    logic [PSEL_W-1:0]    cmt_port_q, cmt_port_d;
    logic [NUM_PORTS-1:0] winc_q, winc_d;
    logic [CNT_W-1:0]     drop_q, drop_d;
`ifdef PKT_RX_CRC_CHECK_EN
    logic [UWIDTH-1:0]    csum_q, csum_d;
`endif

    logic              src_hit;
    logic [PSEL_W-1:0] dst_port;
    logic              crc_ok;
    logic              byte_wr;
    logic              drop_inc;

    function automatic logic [NUM_PORTS-1:0] port_oh(input logic [PSEL_W-1:0] p);
        logic [NUM_PORTS-1:0] v;
        v    = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    always_comb begin
        src_hit = 1'b0;
        for (int i = 0; i < NUM_TS; i++) begin
            if (bus.pdata == TS_LIST[i*UWIDTH +: UWIDTH]) src_hit = 1'b1;
        end
    end

    assign dst_port = bus.pdata[UWIDTH-1 -: PSEL_W];

`ifdef PKT_RX_CRC_CHECK_EN
    assign crc_ok = (bus.pdata == csum_q);
`else
    assign crc_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        trusted_d  = trusted_q;
        keep_d     = keep_q;
        port_d     = port_q;
        len_d      = len_q;
        addr_d     = addr_q;
        stop_d     = |bus.wfull;
        wen_d      = '0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        cmt_pipe_d = {cmt_pipe_q[0], 1'b0};
        cmt_port_d = cmt_port_q;
        winc_d     = cmt_pipe_q[1] ? port_oh(cmt_port_q) : '0;
        byte_wr    = 1'b0;
        drop_inc   = 1'b0;
`ifdef PKT_RX_CRC_CHECK_EN
        csum_d     = csum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.packet_valid_i) begin
                    if (stop_q) begin
                        state_d = S_SKIP;
                    end else begin
                        trusted_d = src_hit;
                        addr_d    = '0;
                        state_d   = S_DST;
`ifdef PKT_RX_CRC_CHECK_EN
                        csum_d    = bus.pdata;
`endif
                    end
                end
            end
            S_SKIP: begin
                if (!bus.packet_valid_i) state_d = S_IDLE;
            end
            default: begin
                if (!bus.packet_valid_i) begin
                    // Sender went quiet mid-frame: the partial frame is never committed.
                    state_d  = S_IDLE;
                    drop_inc = 1'b1;
                end else begin
                    byte_wr = 1'b1;
                    addr_d  = addr_q + 1'b1;
`ifdef PKT_RX_CRC_CHECK_EN
                    csum_d  = csum_q ^ bus.pdata;
`endif
                    case (state_q)
                        S_DST: begin
                            port_d  = dst_port;
                            keep_d  = trusted_q & ~bus.wfull[dst_port];
                            state_d = S_SIZE;
                        end
                        S_SIZE: begin
                            len_d   = bus.pdata[SZ_W-1:0];
                            state_d = (bus.pdata[SZ_W-1:0] == '0) ? S_CRC : S_DATA;
                        end
                        S_DATA: begin
                            if (addr_q == PTR_IN_SZ'(len_q) + PTR_IN_SZ'(1)) state_d = S_CRC;
                        end
                        S_CRC: begin
                            state_d = S_IDLE;
                            if (keep_q && crc_ok) begin
                                cmt_pipe_d[0] = 1'b1;
                                cmt_port_d    = port_q;
                            end else begin
                                drop_inc = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase

        if (byte_wr) begin
            wen_d   = keep_d ? port_oh(port_d) : '0;
            waddr_d = addr_q;
            wdata_d = bus.pdata;
        end
    end

    always_comb begin
        drop_d = drop_q;
        if (drop_inc && (drop_q != {CNT_W{1'b1}})) drop_d = drop_q + 1'b1;
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q    <= S_IDLE;
            trusted_q  <= 1'b0;
            keep_q     <= 1'b0;
            port_q     <= '0;
            len_q      <= '0;
            addr_q     <= '0;
            stop_q     <= 1'b0;
            wen_q      <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            cmt_pipe_q <= '0;
            cmt_port_q <= '0;
            winc_q     <= '0;
            drop_q     <= '0;
`ifdef PKT_RX_CRC_CHECK_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            trusted_q  <= trusted_d;
            keep_q     <= keep_d;
            port_q     <= port_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            stop_q     <= stop_d;
            wen_q      <= wen_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            cmt_pipe_q <= cmt_pipe_d;
            cmt_port_q <= cmt_port_d;
            winc_q     <= winc_d;
            drop_q     <= drop_d;
`ifdef PKT_RX_CRC_CHECK_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign bus.stop_packet_send = stop_q;
    assign bus.wen              = wen_q;
    assign bus.waddr            = waddr_q;
    assign bus.wdata            = wdata_q;
    assign bus.winc             = winc_q;
    assign bus.drop_cnt         = drop_q;

endmodule

// File: tb/tb_packet_receiver_mp.sv
// Bench for packet_receiver_mp: a per-cycle stimulus timeline is built frame by frame and
// the expected write/commit/drop activity is derived from frame-level rules.
module tb_packet_receiver_mp;
  localparam int UW = 8, PW = 2, PA = 4, CW = 8, MAXC = 4096;
`ifdef PKT_RX_CRC_CHECK_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic clk1 = 1'b0;
  logic rst;
  always #5 clk1 = ~clk1;

  packet_receiver_mp_if #(.UWIDTH(UW), .PSEL_W(PW), .PTR_IN_SZ(PA), .CNT_W(CW)) bus ();
  packet_receiver_mp dut (.clk1(clk1), .rst(rst), .bus(bus));

  // stimulus per clock edge k, and outputs expected right after edge k
  bit         s_vld [MAXC];
  logic [7:0] s_dat [MAXC];
  logic [3:0] s_full[MAXC];
  bit         s_rst [MAXC];
  logic [3:0] e_wen [MAXC];
  logic [3:0] e_waddr[MAXC];
  logic [7:0] e_wdata[MAXC];
  logic [3:0] e_winc[MAXC];
  int         e_drop[MAXC];
  int         e_dcnt[MAXC];
  bit         e_stop[MAXC];
  logic [7:0] dbuf[8];
  int n_cyc, cur_k, total, bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, cur_k, got, exp);
    end
  endtask

  // Appends one frame. xm: mask XORed into the correct CRC; trunc>0: only that many bytes,
  // then valid drops (or reset fires when by_rst); force_stop raises wfull just before SRC.
  task automatic add_frame(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] szb,
                           input logic [7:0] xm, input int trunc, input bit by_rst,
                           input bit force_stop, input logic [3:0] dfull, input int gap);
    logic [7:0] pkt[$];
    logic [7:0] cs;
    int s, len, tot, nb, port;
    bit keep, stopped;
    len = int'(szb[2:0]);
    pkt = {src, dst, szb};
    cs = src ^ dst ^ szb;
    for (int i = 0; i < len; i++) begin
      pkt.push_back(dbuf[i]);
      cs = cs ^ dbuf[i];
    end
    pkt.push_back(cs ^ xm);
    tot = pkt.size();
    s = n_cyc;
    if (force_stop) s_full[s-1] = 4'b0010;
    stopped = !s_rst[s-1] && (s_full[s-1] != 4'b0);
    nb = (trunc > 0) ? trunc : tot;
    for (int i = 0; i < nb; i++) begin
      s_vld[s+i] = 1'b1;
      s_dat[s+i] = pkt[i];
    end
    if (stopped) begin
      n_cyc = s + nb + ((gap < 1) ? 1 : gap);
      return;
    end
    if (nb >= 2) s_full[s+1] = s_full[s+1] | dfull;
    port = int'(dst[7:6]);
    keep = (src == 8'h00 || src == 8'h01 || src == 8'h02) && !s_full[s+1][port];
    if (keep) begin
      for (int i = 1; i < nb; i++) begin
        e_wen[s+i]   = 4'(1 << port);
        e_waddr[s+i] = 4'(i - 1);
        e_wdata[s+i] = pkt[i];
      end
    end
    if (trunc > 0) begin
      if (by_rst) begin
        s_rst[s+nb] = 1'b1;
        s_vld[s+nb] = 1'b1;
        s_dat[s+nb] = 8'h5A;
        n_cyc = s + nb + 2 + gap;
      end else begin
        e_drop[s+nb]++;
        n_cyc = s + nb + 1 + gap;
      end
    end else begin
      if (keep && (!CRC_ON || xm == 8'h00)) e_winc[s+tot+1] = 4'(1 << port);
      else e_drop[s+tot-1]++;
      n_cyc = s + tot + gap;
    end
  endtask

  task automatic rnd_frame();
    logic [7:0] src, dst, szb, xm;
    logic [3:0] df;
    int r, tr;
    bit fs;
    r = $urandom_range(0, 3);
    src = (r == 3) ? 8'($urandom) : 8'(r);
    dst = 8'($urandom);
    szb = 8'($urandom);
    for (int i = 0; i < 8; i++) dbuf[i] = 8'($urandom);
    xm = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
    tr = ($urandom_range(0, 7) == 0) ? $urandom_range(1, int'(szb[2:0]) + 3) : 0;
    fs = ($urandom_range(0, 9) == 0);
    df = ($urandom_range(0, 7) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0;
    add_frame(src, dst, szb, xm, tr, 1'b0, fs, df, $urandom_range(0, 2));
  endtask

  initial begin
    int d;
    total = 0;
    bad = 0;
    for (int k = 0; k < MAXC; k++) begin
      s_vld[k] = 1'b0; s_dat[k] = 8'h00; s_full[k] = 4'b0; s_rst[k] = 1'b0;
      e_wen[k] = 4'b0; e_waddr[k] = 4'b0; e_wdata[k] = 8'h00; e_winc[k] = 4'b0;
      e_drop[k] = 0;
    end
    for (int k = 0; k < 3; k++) s_rst[k] = 1'b1;
    n_cyc = 4;

    dbuf[0] = 8'hAA; dbuf[1] = 8'h55;
    add_frame(8'h01, 8'h85, 8'h02, 8'h00, 0, 1'b0, 1'b0, 4'b0, 2);
    dbuf[0] = 8'h33;
    add_frame(8'h07, 8'h10, 8'h01, 8'h00, 0, 1'b0, 1'b0, 4'b0, 2);
    add_frame(8'h00, 8'hC0, 8'h00, 8'h00, 0, 1'b0, 1'b0, 4'b0, 1);
    add_frame(8'h00, 8'hC0, 8'h00, 8'h0D, 0, 1'b0, 1'b0, 4'b0, 2);
    dbuf[0] = 8'h11;
    add_frame(8'h01, 8'h40, 8'h01, 8'h00, 0, 1'b0, 1'b1, 4'b0, 2);
    add_frame(8'h02, 8'h45, 8'h01, 8'h00, 0, 1'b0, 1'b0, 4'b0010, 2);
    dbuf[0] = 8'h9C; dbuf[1] = 8'h3E;
    add_frame(8'h00, 8'h12, 8'h01, 8'h00, 0, 1'b0, 1'b0, 4'b0, 0);
    add_frame(8'h01, 8'hC5, 8'h02, 8'h00, 0, 1'b0, 1'b0, 4'b0, 2);
    for (int f = 0; f < 70; f++) rnd_frame();
    for (int i = 0; i < 8; i++) dbuf[i] = 8'($urandom);
    add_frame(8'h01, 8'h80, 8'h05, 8'h00, 4, 1'b1, 1'b0, 4'b0, 1);
    add_frame(8'h01, 8'h80, 8'h05, 8'h00, 5, 1'b0, 1'b0, 4'b0, 1);
    for (int f = 0; f < 270; f++) add_frame(8'h01, 8'h00, 8'h00, 8'h00, 1, 1'b0, 1'b0, 4'b0, 0);
    add_frame(8'h02, 8'h7F, 8'h03, 8'h00, 0, 1'b0, 1'b0, 4'b0, 1);
    add_frame(8'h09, 8'h7F, 8'h00, 8'h00, 0, 1'b0, 1'b0, 4'b0, 4);

    d = 0;
    for (int k = 0; k < n_cyc; k++) begin
      if (s_rst[k]) d = 0;
      else d = (d + e_drop[k] > 255) ? 255 : d + e_drop[k];
      e_dcnt[k] = d;
      e_stop[k] = !s_rst[k] && (s_full[k] != 4'b0);
    end

    for (int k = 0; k < n_cyc; k++) begin
      rst = s_rst[k];
      bus.packet_valid_i = s_vld[k];
      bus.pdata = s_dat[k];
      bus.wfull = s_full[k];
      @(posedge clk1);
      @(negedge clk1);
      cur_k = k;
      chk("wen", 32'(bus.wen), 32'(e_wen[k]));
      chk("winc", 32'(bus.winc), 32'(e_winc[k]));
      chk("drop_cnt", 32'(bus.drop_cnt), 32'(e_dcnt[k]));
      chk("stop", 32'(bus.stop_packet_send), 32'(e_stop[k]));
      if (e_wen[k] != 4'b0) begin
        chk("waddr", 32'(bus.waddr), 32'(e_waddr[k]));
        chk("wdata", 32'(bus.wdata), 32'(e_wdata[k]));
      end
      if (s_rst[k]) begin
        chk("rst_waddr", 32'(bus.waddr), 32'd0);
        chk("rst_wdata", 32'(bus.wdata), 32'd0);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
